// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-file controller.
package spi_reg_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      TX      = 2'd3
   } state_e;

   localparam int CMD_RW_BIT = 7;
   localparam int CMD_ADDR_W = 7;

   // True when the 7-bit command address indexes an existing register.
   function automatic logic addr_in_range(input logic [CMD_ADDR_W-1:0] addr, input int aw);
      logic [31:0] w_ext;
      w_ext = {{(32-CMD_ADDR_W){1'b0}}, addr};
      return (w_ext >> aw) == 32'd0;
   endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-level handshake between the SPI slave shifter and the register controller.
interface spi_reg_ctrl_if;

   logic       ss;
   logic [7:0] spi_din;
   logic       spi_done;
   logic [7:0] spi_dout;

   modport master (
      output ss,
      output spi_din,
      output spi_done,
      input  spi_dout
   );

   modport slave (
      input  ss,
      input  spi_din,
      input  spi_done,
      output spi_dout
   );

endinterface

// File: rtl/spi_reg_bank.sv
// Control register array with an SPI and a hardware write port; SPI wins on a
// same-address commit and the dropped hardware write is flagged for one cycle.
module spi_reg_bank
   import spi_reg_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_spi_we,
   input  logic [ADDR_W-1:0]          i_spi_addr,
   input  logic [7:0]                 i_spi_wdata,
   input  logic                       i_hw_we,
   input  logic [ADDR_W-1:0]          i_hw_addr,
   input  logic [7:0]                 i_hw_wdata,
   input  logic [ADDR_W-1:0]          i_rd_addr,
   output logic [7:0]                 o_rd_data,
   output logic [7:0]                 o_hw_rdata,
   output logic [8*(2**ADDR_W)-1:0]   o_regs_flat,
   output logic                       o_collision
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [NUM_REGS-1:0][7:0] r_regs;
   logic                     r_collision;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_regs      <= '0;
         r_collision <= 1'b0;
      end else begin
         r_collision <= i_spi_we & i_hw_we & (i_spi_addr == i_hw_addr);
         if (i_hw_we)
            r_regs[i_hw_addr] <= i_hw_wdata;
         // Later assignment overrides the hw write on an address clash.
         if (i_spi_we)
            r_regs[i_spi_addr] <= i_spi_wdata;
      end
   end

   assign o_rd_data   = r_regs[i_rd_addr];
   assign o_hw_rdata  = r_regs[i_hw_addr];
   assign o_regs_flat = r_regs;
   assign o_collision = r_collision;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command decoder and sequencing FSM in front of the shared register bank.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for the command byte {rw, addr}
//   RD_WAIT | snapshot reg[addr] into spi_dout, wait for the dummy byte
//   WR_WAIT | waiting for the data byte to commit
//   TX      | spi_dout held while the master clocks the read data out
module spi_reg_ctrl
   import spi_reg_pkg::*;
#(
   parameter int                       ADDR_W    = 4,
   parameter logic [(2**ADDR_W)-1:0]   RO_MASK   = '0,
   parameter logic [7:0]               ERR_RDATA = 8'hFF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   spi_reg_ctrl_if.slave              spi,
   input  logic                       hw_we,
   input  logic [ADDR_W-1:0]          hw_addr,
   input  logic [7:0]                 hw_wdata,
   output logic [7:0]                 hw_rdata,
   output logic [8*(2**ADDR_W)-1:0]   regs_flat,
   output logic                       spi_wr_pulse,
   output logic [ADDR_W-1:0]          spi_wr_addr,
   output logic                       err_pulse,
   output logic                       hw_collision
);

   state_e                  r_state;
   logic [CMD_ADDR_W-1:0]   r_addr;
   logic                    r_rd_pend;
   logic [7:0]              r_dout;
   logic                    r_wr_pulse;
   logic [ADDR_W-1:0]       r_wr_addr;
   logic                    r_err;

   logic                    w_done;
   logic                    w_in_range;
   logic                    w_ro;
   logic                    w_wr_ok;
   logic [7:0]              w_rd_data;

   assign w_done     = spi.spi_done & ~spi.ss;
   assign w_in_range = addr_in_range(r_addr, ADDR_W);
   assign w_ro       = RO_MASK[r_addr[ADDR_W-1:0]];
   assign w_wr_ok    = (r_state == WR_WAIT) & w_done & w_in_range & ~w_ro;

   spi_reg_bank #(
      .ADDR_W (ADDR_W)
   ) u_bank (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_spi_we    (w_wr_ok),
      .i_spi_addr  (r_addr[ADDR_W-1:0]),
      .i_spi_wdata (spi.spi_din),
      .i_hw_we     (hw_we),
      .i_hw_addr   (hw_addr),
      .i_hw_wdata  (hw_wdata),
      .i_rd_addr   (r_addr[ADDR_W-1:0]),
      .o_rd_data   (w_rd_data),
      .o_hw_rdata  (hw_rdata),
      .o_regs_flat (regs_flat),
      .o_collision (hw_collision)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_rd_pend  <= 1'b0;
         r_dout     <= 8'h00;
         r_wr_pulse <= 1'b0;
         r_wr_addr  <= '0;
         r_err      <= 1'b0;
      end else begin
         r_wr_pulse <= 1'b0;
         r_err      <= 1'b0;
         if (spi.ss) begin
            // Frame abort: drop any pending access, keep spi_dout as is.
            r_state   <= IDLE;
            r_rd_pend <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (spi.spi_done) begin
                     r_addr    <= spi.spi_din[CMD_ADDR_W-1:0];
                     r_rd_pend <= spi.spi_din[CMD_RW_BIT];
                     r_state   <= spi.spi_din[CMD_RW_BIT] ? RD_WAIT : WR_WAIT;
                  end
               end
               RD_WAIT: begin
                  if (r_rd_pend) begin
                     r_rd_pend <= 1'b0;
                     r_dout    <= w_in_range ? w_rd_data : ERR_RDATA;
                     r_err     <= ~w_in_range;
                  end
                  if (spi.spi_done)
                     r_state <= TX;
               end
               WR_WAIT: begin
                  if (spi.spi_done) begin
                     r_state <= IDLE;
                     if (w_wr_ok) begin
                        r_wr_pulse <= 1'b1;
                        r_wr_addr  <= r_addr[ADDR_W-1:0];
                     end else begin
                        r_err <= 1'b1;
                     end
                  end
               end
               TX: begin
                  if (spi.spi_done)
                     r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign spi.spi_dout  = r_dout;
   assign spi_wr_pulse  = r_wr_pulse;
   assign spi_wr_addr   = r_wr_addr;
   assign err_pulse     = r_err;

endmodule
